// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative unsigned MULTU/DIVU unit with HI/LO result registers
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic         Op,
  input  logic [N-1:0] Operand_A,
  input  logic [N-1:0] Operand_B,
  input  logic         Result_Sel,
  output logic         Busy,
  output logic         Done,
  output logic         Div_Zero,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo,
  output logic [N-1:0] Result
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          op_q;
  logic          b_zero_q;
  // w_hi: P_hi (multiply) or remainder R (divide), one spare bit for carry/sign room
  logic [N:0]    w_hi;
  // w_lo: P_lo (multiply) or quotient Q (divide)
  logic [N-1:0]  w_lo;
  // w_d: multiplicand (multiply) or divisor (divide)
  logic [N-1:0]  w_d;

  logic [N:0]    mul_sum;
  logic [N:0]    div_shift;
  logic [N+1:0]  div_trial;
  logic [N:0]    hi_nxt;
  logic [N-1:0]  lo_nxt;
  logic          last_iter;

  assign last_iter = (state == RUN) && (cnt == LAST);

  // One iteration of shift-add multiply or restoring divide from the current working registers
  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    div_trial = '0;
    hi_nxt    = w_hi;
    lo_nxt    = w_lo;
    if (!op_q) begin
      mul_sum = {1'b0, w_hi[N-1:0]} + (w_lo[0] ? {1'b0, w_d} : '0);
      hi_nxt  = {1'b0, mul_sum[N:1]};
      lo_nxt  = {mul_sum[0], w_lo[N-1:1]};
    end else begin
      div_shift = {w_hi[N-1:0], w_lo[N-1]};
      div_trial = {1'b0, div_shift} - {2'b00, w_d};
      if (!div_trial[N+1]) begin
        hi_nxt = div_trial[N:0];
        lo_nxt = {w_lo[N-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift;
        lo_nxt = {w_lo[N-2:0], 1'b0};
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; Start outside IDLE is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch on accept, iteration during RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      op_q     <= 1'b0;
      b_zero_q <= 1'b0;
      w_hi     <= '0;
      w_lo     <= '0;
      w_d      <= '0;
    end else if (state == IDLE && Start) begin
      cnt      <= '0;
      op_q     <= Op;
      b_zero_q <= Op && (Operand_B == '0);
      w_hi     <= '0;
      w_lo     <= Op ? Operand_A : Operand_B;
      w_d      <= Op ? Operand_B : Operand_A;
    end else if (state == RUN) begin
      cnt  <= cnt + CW'(1);
      w_hi <= hi_nxt;
      w_lo <= lo_nxt;
    end
  end

  // Result registers change only on the final iteration edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Hi       <= '0;
      Lo       <= '0;
      Div_Zero <= 1'b0;
    end else if (last_iter) begin
      Hi       <= hi_nxt[N-1:0];
      Lo       <= lo_nxt;
      Div_Zero <= b_zero_q;
    end
  end

  assign Busy   = (state == RUN);
  assign Done   = (state == DONE);
  assign Result = Result_Sel ? Hi : Lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic         Start;
  logic         Op;
  logic [N-1:0] Operand_A;
  logic [N-1:0] Operand_B;
  logic         Result_Sel;
  logic         Busy;
  logic         Done;
  logic         Div_Zero;
  logic [N-1:0] Hi;
  logic [N-1:0] Lo;
  logic [N-1:0] Result;

  int passed = 0;
  int total  = 0;

  mult_div_unit #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Op         (Op),
    .Operand_A  (Operand_A),
    .Operand_B  (Operand_B),
    .Result_Sel (Result_Sel),
    .Busy       (Busy),
    .Done       (Done),
    .Div_Zero   (Div_Zero),
    .Hi         (Hi),
    .Lo         (Lo),
    .Result     (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a request at the next negedge; returns #1 after the accept edge E0
  task automatic start_op(input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    Start = 1'b1; Op = op; Operand_A = a; Operand_B = b;
    @(posedge clk); #1;
    Start = 1'b0; Op = ~op; Operand_A = $urandom; Operand_B = $urandom;
  endtask

  // Full operation with exact Busy/Done timing and result checks
  task automatic run_op(input string tag, input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo, input logic exp_dz);
    logic busy_ok;
    logic [N-1:0] old_hi, old_lo;
    old_hi = Hi; old_lo = Lo;
    start_op(op, a, b);
    busy_ok = 1'b1;
    for (int i = 1; i < N; i++) begin
      if (!(Busy === 1'b1 && Done === 1'b0)) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    if (!(Busy === 1'b1 && Done === 1'b0 && Hi === old_hi && Lo === old_lo)) busy_ok = 1'b0;
    check({tag, " busy_hold"}, N'(busy_ok), N'(1));
    @(posedge clk); #1;
    check({tag, " done"}, N'({Busy, Done}), N'(2'b01));
    check({tag, " hi"}, Hi, exp_hi);
    check({tag, " lo"}, Lo, exp_lo);
    check({tag, " div_zero"}, N'(Div_Zero), N'(exp_dz));
    @(posedge clk); #1;
    check({tag, " idle"}, N'({Busy, Done}), N'(2'b00));
  endtask

  initial begin
    reset = 1'b0; Start = 1'b0; Op = 1'b0; Operand_A = '0; Operand_B = '0; Result_Sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy_done", N'({Busy, Done}), N'(2'b00));
    check("reset div_zero", N'(Div_Zero), N'(0));
    check("reset hi", Hi, 32'h0);
    check("reset lo", Lo, 32'h0);
    @(negedge clk) reset = 1'b1;

    run_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0);
    run_op("mulmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    Result_Sel = 1'b0; #1;
    check("result_lo", Result, 32'd14);
    Result_Sel = 1'b1; #1;
    check("result_hi", Result, 32'd2);
    Result_Sel = 1'b0;
    run_op("div25_0", 1'b1, 32'd25, 32'd0, 32'd25, 32'hFFFFFFFF, 1'b1);
    run_op("mul3x3", 1'b0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

    // Start during RUN and during DONE must be ignored
    start_op(1'b0, 32'h1234, 32'h10);
    repeat (5) @(posedge clk);
    #1;
    Start = 1'b1; Op = 1'b1; Operand_A = 32'd77; Operand_B = 32'd5;
    check("ign run hi_hold", Hi, 32'd0);
    check("ign run lo_hold", Lo, 32'd9);
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (N - 6) @(posedge clk);
    #1;
    check("ign done pulse", N'({Busy, Done}), N'(2'b01));
    Start = 1'b1; Op = 1'b1; Operand_A = 32'd99; Operand_B = 32'd4;
    @(posedge clk); #1;
    Start = 1'b0;
    check("ign not_restarted", N'({Busy, Done}), N'(2'b00));
    check("ign lo", Lo, 32'h12340);
    check("ign hi", Hi, 32'h0);
    @(posedge clk); #1;
    check("ign still_idle", N'({Busy, Done}), N'(2'b00));

    // Asynchronous reset in the middle of a divide
    start_op(1'b1, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", N'(Busy), N'(0));
    check("abort lo", Lo, 32'h0);
    check("abort hi", Hi, 32'h0);
    @(negedge clk) reset = 1'b1;
    run_op("mul5x5", 1'b0, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative unsigned multiply/divide unit with HI/LO result registers, sitting directly downstream of the register file. It consumes the two register-file read ports (Read_Data_1, Read_Data_2) as operands and runs a one-bit-per-cycle shift-add multiply or restoring divide. It holds the result in HI/LO and returns a selected HI or LO word toward the register-file write-data path (MFHI/MFLO). The decode stage uses busy/done to stall.

## Interface
- N, 32, operand/result word width (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Start  input  1  operation request; accepted only in IDLE
- Op  input  1  0 = MULTU, 1 = DIVU; sampled with Start
- Operand_A  input  N  multiplicand / dividend (from Read_Data_1)
- Operand_B  input  N  multiplier / divisor (from Read_Data_2)
- Result_Sel  input  1  0 = LO, 1 = HI on Result
- Busy  output  1  high while iterating
- Done  output  1  one-cycle completion pulse
- Div_Zero  output  1  last completed DIVU had divisor 0
- Hi  output  N  HI register
- Lo  output  N  LO register
- Result  output  N  combinational: Result_Sel ? Hi : Lo

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if Start=1 at an edge, latch Op, Operand_A and Operand_B into working registers, clear the iteration counter, and go to RUN. Otherwise stay in IDLE.
- RUN: one iteration per edge, counter increments. After the N-th iteration (counter = N-1 at that edge), write Hi/Lo from the working registers and go to DONE.
- DONE: go to IDLE unconditionally on the next edge.
- Start in RUN or DONE is ignored; requests are not queued.
- MULTU (2N-bit accumulator {P_hi, P_lo}):
  - Initialise: P_hi = 0, P_lo = Operand_B.
  - Each iteration: if P_lo[0], add Operand_A to P_hi with an N+1-bit carry. Then shift {carry, P_hi, P_lo} right by 1.
  - Final result: Hi = product[2N-1:N], Lo = product[N-1:0].
- DIVU (restoring): remainder R (N+1 bits) = 0, quotient Q = Operand_A.
  - Each iteration: shift {R, Q} left by 1, then trial = R - {0, Operand_B}.
  - If trial is non-negative: R = trial, Q[0] = 1. Otherwise Q[0] = 0.
  - Final result: Lo = Q, Hi = R[N-1:0].
- Divide by zero needs no special-casing: the algorithm naturally yields Lo = all ones and Hi = dividend. Div_Zero is set at the completion write when Operand_B was 0. It is cleared at the completion write of any other operation.
- Hi, Lo and Div_Zero change only at the completion edge (entry to DONE). They hold their values throughout RUN, so MFHI/MFLO during RUN return the previous result.

## Timing
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - Busy = 0, Done = 0, Div_Zero = 0, Hi = 0, Lo = 0.
  - Working registers and counter are cleared.
  - An in-flight operation is aborted with no write-back.
- Start sampled at edge E0:
  - Busy = 1 from after E0 through edge E0+N.
  - Hi/Lo are updated at edge E0+N.
  - Done = 1 (Busy = 0) for the single cycle between E0+N and E0+N+1.
  - The unit is back in IDLE after E0+N+1, so the earliest next accept is edge E0+N+1.
- Total: N+2 edges per operation including the accept edge.
- Busy and Done are registered (decoded from state) and are never high together.
- Result is purely combinational from Hi, Lo and Result_Sel, with zero latency.
- Operand_A and Operand_B may change freely after E0; only the latched copies are used.
- Counter width is $clog2(N). It must not wrap before the N-th iteration.

## Test plan
- Reset, then MULTU with A = 7, B = 6 (N = 32), Start at edge 0 -> Busy for 32 cycles; Done pulse after edge 32; Hi = 0x00000000, Lo = 0x0000002A; Div_Zero = 0.
- MULTU A = 0xFFFFFFFF, B = 0xFFFFFFFF -> Hi = 0xFFFFFFFE, Lo = 0x00000001 (exercises the carry-out).
- DIVU A = 100, B = 7 -> Lo = 14, Hi = 2. Result_Sel toggles Result between 14 and 2 in the same cycle.
- DIVU A = 25, B = 0 -> Lo = 0xFFFFFFFF, Hi = 25, Div_Zero = 1. A following MULTU 3×3 -> Lo = 9, Div_Zero = 0.
- Start pulsed during RUN and during DONE with different operands -> ignored; Hi/Lo reflect only the first operation; Hi/Lo hold their old values during RUN.
- reset driven low at cycle 10 of a DIVU -> outputs go to 0 asynchronously. After release, a new MULTU 5×5 completes with Lo = 25 in N+2 edges.
